mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux datapath among four requesters.
- Accepts per-requester request lines and issues a registered one-hot grant.
- Drives the mux select pair (sel[1] to s1, sel[0] to s0) so the granted input reaches the mux output.
- Bounds each ownership to MAX_BURST cycles when other requesters are waiting.

Parameters:
- MAX_BURST, default 4: maximum consecutive grant cycles per owner while another request is pending. Legal range 1..15.
- CNT_W, default 4: burst counter width. Must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req, input, 4: request, bit k from requester k. A requester holds its bit high while it wants the mux.
- gnt, output, 4: registered one-hot grant, or all zero.
- sel, output, 2: registered mux select equal to the index of the granted requester. Holds its last value when idle.
- busy, output, 1: registered; high while any grant is active.
- burst_cnt, output, CNT_W: registered count of cycles the current owner has held the grant (debug/verification).

Behaviour:
- Reset (async assert, sync release):
  - gnt=0, sel=2'b00, busy=0, burst_cnt=0, state=IDLE.
  - Internal last-owner pointer ptr=3, so the first priority order is 0,1,2,3.
- Priority rule: search starts at ptr+1 mod 4 and wraps through all four indices. The first set req bit wins.
- FSM states: IDLE, OWN.
- IDLE:
  - If req==0, stay in IDLE; outputs unchanged.
  - Else pick winner w by the priority rule. Next edge: gnt=1<<w, sel=w, busy=1, burst_cnt=1, state=OWN.
  - Latency from req sampled high to gnt high is exactly 1 clock.
- OWN, owner o:
  - Release: req[o]==0.
    - If another request is pending, pick winner w (ptr updated to o first, so o has lowest priority). Next edge: gnt=1<<w, sel=w, burst_cnt=1. No idle bubble.
    - If no request is pending, next edge: gnt=0, busy=0, burst_cnt=0, sel holds o, ptr=o, state=IDLE.
  - Burst limit: req[o]==1 and burst_cnt==MAX_BURST.
    - If any other req is pending, force a handover exactly as for release (ptr=o, winner excludes o). The owner sees gnt drop after exactly MAX_BURST cycles.
    - If no other req is pending, o keeps the grant and burst_cnt reloads to 1.
  - Otherwise: hold the grant; burst_cnt increments by 1 and never exceeds MAX_BURST.
- Invariants:
  - gnt is always one-hot or zero.
  - When gnt!=0, sel==index(gnt).
  - busy == |gnt.
- Simultaneous events:
  - A new request arriving in the same cycle the owner releases takes part in that cycle's arbitration.
  - A requester dropping its req in the same cycle it would have been chosen is not granted (arbitration uses the current-cycle req).
- Requests are level, not latched. A requester that drops req before being granted loses its turn; there is no queue.
- Reset mid-grant: gnt drops immediately (asynchronously), ptr returns to 3, and arbitration restarts from IDLE after rst_n deasserts.
- MAX_BURST=1 degenerates to strict per-cycle rotation among the active requesters.

Test Plan:
- Reset: drive rst_n=0 with req=4'b1111 -> gnt=0, sel=0, busy=0. Release reset -> after 1 clk gnt=4'b0001, sel=0, burst_cnt=1.
- Single requester: req=4'b0100 held for 10 clk, MAX_BURST=4 -> gnt=4'b0100 throughout, burst_cnt cycles 1,2,3,4,1,2,... Drop req -> next clk gnt=0, busy=0, sel stays 2.
- Full contention: req=4'b1111 held, MAX_BURST=4 -> grants rotate 0,1,2,3,0, each held exactly 4 clk, with no zero-gnt cycle between owners.
- Early release with wrap: owner=3, req=4'b1001, requester 3 drops req -> next clk gnt=4'b0001, sel=0. A later request by 3 is placed behind 0.
- Fairness after release: ptr=1, req=4'b0011 rising together from IDLE -> gnt=4'b0001 (0 follows 1 in the search order from 2). Next, 0 holds for MAX_BURST -> then gnt=4'b0010.
- Async reset mid-burst: owner=2 with burst_cnt=2, pulse rst_n low between clock edges -> gnt=0 immediately. After release with req=4'b0100 -> gnt=4'b0100 one clk later, burst_cnt=1.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter granting one of four requesters ownership of a shared 4:1 mux.
// Registered one-hot grant, mux select and burst counter; ownership is capped at MAX_BURST under contention.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [CNT_W-1:0] burst_cnt
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;

  logic [1:0] owner;
  logic [3:0] others;
  logic [1:0] win_idle;
  logic [1:0] win_own;
  logic       leave;

  // First set bit of r, searching from p+1 and wrapping, so index p is visited last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign owner    = sel_q;
  assign others   = req & ~(4'b0001 << owner);
  assign win_idle = rr_pick(req, ptr_q);
  assign win_own  = rr_pick(others, owner);
  assign leave    = !req[owner] || ((cnt_q == MAX_CNT) && (|others));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWN;
          gnt_d   = 4'b0001 << win_idle;
          sel_d   = win_idle;
          busy_d  = 1'b1;
          cnt_d   = ONE_CNT;
        end
      end
      OWN: begin
        if (leave) begin
          ptr_d = owner;
          if (|others) begin
            gnt_d = 4'b0001 << win_own;
            sel_d = win_own;
            cnt_d = ONE_CNT;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end else if (cnt_q == MAX_CNT) begin
          cnt_d = ONE_CNT;
        end else begin
          cnt_d = cnt_q + ONE_CNT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a behavioural model queues the expected
// post-edge outputs at each rising edge; they are compared on the following falling edge.
module tb_mux4_rr_arbiter;

  localparam int MB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req   = 4'h0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] burst_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic [3:0] c;
  } exp_t;

  exp_t exp_q[$];

  int m_own  = -1;
  int m_last = 3;
  int m_cnt  = 0;
  int m_sel  = 0;

  mux4_rr_arbiter #(.MAX_BURST(MB), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .busy      (busy),
    .burst_cnt (burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int search(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r);
    logic [3:0] oth;
    int w;
    if (m_own < 0) begin
      if (r != 4'h0) begin
        w = search(r, m_last);
        m_own = w; m_sel = w; m_cnt = 1;
      end
    end else begin
      oth = r;
      oth[m_own] = 1'b0;
      if (!r[m_own] || (m_cnt == MB && oth != 4'h0)) begin
        m_last = m_own;
        if (oth != 4'h0) begin
          w = search(oth, m_last);
          m_own = w; m_sel = w; m_cnt = 1;
        end else begin
          m_own = -1; m_cnt = 0;
        end
      end else if (m_cnt == MB) begin
        m_cnt = 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  always @(negedge rst_n) begin
    m_own = -1; m_last = 3; m_cnt = 0; m_sel = 0;
    exp_q.delete();
  end

  always @(posedge clk) begin
    exp_t e;
    if (rst_n) begin
      model_step(req);
      e.g = (m_own < 0) ? 4'h0 : (4'b0001 << m_own);
      e.s = 2'(m_sel);
      e.b = (m_own >= 0);
      e.c = 4'(m_cnt);
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check_eq("rst_gnt", {28'h0, gnt}, 32'h0);
      check_eq("rst_sel", {30'h0, sel}, 32'h0);
      check_eq("rst_busy", {31'h0, busy}, 32'h0);
      check_eq("rst_cnt", {28'h0, burst_cnt}, 32'h0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("gnt", {28'h0, gnt}, {28'h0, e.g});
      check_eq("sel", {30'h0, sel}, {30'h0, e.s});
      check_eq("busy", {31'h0, busy}, {31'h0, e.b});
      check_eq("burst_cnt", {28'h0, burst_cnt}, {28'h0, e.c});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    req = 4'hF;
    #1 rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    // Full contention: expect rotation 0,1,2,3,0 with MB cycles each.
    cyc(22);
    req = 4'h0;
    cyc(3);
    // Single requester crossing the burst limit with nobody else waiting.
    req = 4'b0100;
    cyc(10);
    req = 4'h0;
    cyc(3);
    // Owner 3 releases while 0 waits: wrap to 0, then 3 queues behind 0.
    req = 4'b1000;
    cyc(2);
    req = 4'b1001;
    cyc(1);
    req = 4'b0001;
    cyc(1);
    req = 4'b1001;
    cyc(10);
    req = 4'h0;
    cyc(2);
    // Last owner 1, then 0 and 1 rise together.
    req = 4'b0010;
    cyc(2);
    req = 4'h0;
    cyc(2);
    req = 4'b0011;
    cyc(10);
    req = 4'h0;
    cyc(2);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      cyc(1);
    end
    req = 4'h0;
    cyc(3);
    // Asynchronous reset in the middle of a burst owned by requester 2.
    req = 4'b0100;
    cyc(3);
    rst_n = 1'b0;
    #1;
    check_eq("async_gnt", {28'h0, gnt}, 32'h0);
    check_eq("async_busy", {31'h0, busy}, 32'h0);
    check_eq("async_cnt", {28'h0, burst_cnt}, 32'h0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    #2;
    check_eq("post_rst_gnt", {28'h0, gnt}, 32'h4);
    check_eq("post_rst_cnt", {28'h0, burst_cnt}, 32'h1);
    req = 4'h0;
    cyc(3);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
